// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light codes, phase-controller state encoding and index helper
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_GREEN  = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [1:0] LIGHT_OFF    = 2'b11;

    // Width of the active_phase port; covers up to 8 phases.
    localparam int ACTIVE_W = 3;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } phase_state_e;

    // Folds idx back into 0..n-1. idx never exceeds 2*n-1 here (active + 1..n),
    // so a single conditional subtract is enough.
    function automatic logic [3:0] wrap_index(input logic [3:0] idx, input int n);
        logic [3:0] n4;
        n4 = 4'(n);
        return (idx >= n4) ? (idx - n4) : idx;
    endfunction

endpackage

// File: rtl/sec_tick_timer.sv
// rtl/sec_tick_timer.sv - one-second prescaler plus seconds down-counter
//  clk, reset   clock, asynchronous active-low reset
//  load         restart: prescaler to 0, counter to load_val
//  load_val     seconds to count down from
//  tick         one clk pulse when the prescaler wraps (once per second)
//  expired      counter is 0
//  last_sec     this tick takes the counter from 1 to 0
module sec_tick_timer #(
    parameter int CLK_HZ    = 10000,
    parameter int TW        = 8,
    parameter int RESET_VAL = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          tick,
    output logic          expired,
    output logic          last_sec
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [PW-1:0] presc_q;
    logic [TW-1:0] count_q;

    assign tick     = (presc_q == PW'(CLK_HZ - 1));
    assign expired  = (count_q == '0);
    assign last_sec = tick && (count_q == TW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            count_q <= TW'(RESET_VAL);
        end else if (load) begin
            presc_q <= '0;
            count_q <= load_val;
        end else begin
            presc_q <= tick ? '0 : (presc_q + PW'(1));
            if (tick && !expired) begin
                count_q <= count_q - TW'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - sensor-actuated controller for N conflicting traffic phases
//  clk           system clock
//  reset         asynchronous active-low reset
//  enable        1 = normal operation, 0 = flash mode
//  sensor        asynchronous vehicle sensors, one per phase
//  light         phase p light code at [2p+1:2p]
//  active_phase  phase currently owning green/yellow
//  demand        latched pending requests
module traffic_phase_ctrl #(
    parameter int N_PHASES  = 3,
    parameter int CLK_HZ    = 10000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int TW        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_PHASES-1:0]   sensor,
    output logic [2*N_PHASES-1:0] light,
    output logic [2:0]            active_phase,
    output logic [N_PHASES-1:0]   demand
);

    import traffic_pkg::*;

    phase_state_e          state_q, state_d;
    logic [ACTIVE_W-1:0]   active_q, active_d, next_phase;
    logic                  first_q, first_d;
    logic [N_PHASES-1:0]   sync1_q, sync2_q;
    logic [N_PHASES-1:0]   demand_q, demand_d;
    logic [TW-1:0]         elapsed_q, elapsed_d;
    logic                  flash_on_q, flash_on_d;
    logic [2*N_PHASES-1:0] light_q, light_d;

    logic                  tmr_load;
    logic [TW-1:0]         tmr_val;
    logic                  tick, expired, last_sec;
    logic                  sec_done, max_done, other_demand, own_sensor, entering_green;
    logic [7:0]            demand8, sync8;
    logic [3:0]            cand;

    sec_tick_timer #(
        .CLK_HZ    (CLK_HZ),
        .TW        (TW),
        .RESET_VAL (ALLRED_T)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tick),
        .expired  (expired),
        .last_sec (last_sec)
    );

    // Firing on the tick that reaches zero keeps every state exactly its
    // count of whole seconds long.
    assign sec_done = expired || last_sec;

    // Green elapsed saturates at GREEN_MAX, so the same test covers the
    // ongoing-demand case and the demand-arrives-after-long-rest case.
    assign max_done = (elapsed_q >= TW'(GREEN_MAX)) ||
                      (tick && (elapsed_q == TW'(GREEN_MAX - 1)));

    assign demand8      = 8'(demand_q);
    assign sync8        = 8'(sync2_q);
    assign other_demand = |(demand8 & ~(8'd1 << active_q));
    assign own_sensor   = sync8[active_q];

    // Round-robin search from active+1; walking from the far end means the
    // nearest pending phase is the last one written.
    always_comb begin
        cand       = wrap_index({1'b0, active_q} + 4'd1, N_PHASES);
        next_phase = cand[ACTIVE_W-1:0];
        for (int k = N_PHASES; k >= 1; k--) begin
            cand = wrap_index({1'b0, active_q} + 4'(k), N_PHASES);
            if (demand8[cand[2:0]]) begin
                next_phase = cand[ACTIVE_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        first_d    = first_q;
        tmr_load   = 1'b0;
        tmr_val    = TW'(ALLRED_T);
        elapsed_d  = elapsed_q;
        flash_on_d = flash_on_q;

        case (state_q)
            ST_ALLRED: begin
                if (sec_done) begin
                    tmr_load = 1'b1;
                    if (!enable) begin
                        state_d = ST_FLASH;
                    end else begin
                        state_d  = ST_GREEN;
                        tmr_val  = TW'(GREEN_MIN);
                        // The first green after reset always goes to phase 0.
                        active_d = first_q ? '0 : next_phase;
                        first_d  = 1'b0;
                    end
                end
            end
            ST_GREEN: begin
                if (!enable || (sec_done && other_demand && (!own_sensor || max_done))) begin
                    state_d  = ST_YELLOW;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(YELLOW_T);
                end
            end
            ST_YELLOW: begin
                if (sec_done) begin
                    state_d  = ST_ALLRED;
                    tmr_load = 1'b1;
                end
            end
            ST_FLASH: begin
                if (enable) begin
                    state_d  = ST_ALLRED;
                    tmr_load = 1'b1;
                end
            end
            default: begin
                state_d  = ST_ALLRED;
                tmr_load = 1'b1;
            end
        endcase

        if (tmr_load) begin
            elapsed_d = '0;
        end else if ((state_q == ST_GREEN) && tick && (elapsed_q < TW'(GREEN_MAX))) begin
            elapsed_d = elapsed_q + TW'(1);
        end

        if (tmr_load && (state_d == ST_FLASH)) begin
            flash_on_d = 1'b1;
        end else if ((state_q == ST_FLASH) && tick) begin
            flash_on_d = !flash_on_q;
        end
    end

    assign entering_green = (state_q == ST_ALLRED) && (state_d == ST_GREEN);

    // The phase being granted green clears even if its sensor is still high;
    // the phase already in green never re-requests itself.
    always_comb begin
        demand_d = demand_q;
        for (int p = 0; p < N_PHASES; p++) begin
            if (sync2_q[p] && !((state_q == ST_GREEN) && (active_q == ACTIVE_W'(p)))) begin
                demand_d[p] = 1'b1;
            end
            if (entering_green && (active_d == ACTIVE_W'(p))) begin
                demand_d[p] = 1'b0;
            end
        end
    end

    always_comb begin
        light_d = '0;
        for (int p = 0; p < N_PHASES; p++) begin
            case (state_q)
                ST_GREEN: begin
                    light_d[2*p +: 2] = (active_q == ACTIVE_W'(p)) ? LIGHT_GREEN : LIGHT_RED;
                end
                ST_YELLOW: begin
                    light_d[2*p +: 2] = (active_q == ACTIVE_W'(p)) ? LIGHT_YELLOW : LIGHT_RED;
                end
                ST_FLASH: begin
                    light_d[2*p +: 2] = flash_on_q ? LIGHT_YELLOW : LIGHT_OFF;
                end
                default: begin
                    light_d[2*p +: 2] = LIGHT_RED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ALLRED;
            active_q   <= '0;
            first_q    <= 1'b1;
            sync1_q    <= '0;
            sync2_q    <= '0;
            demand_q   <= '0;
            elapsed_q  <= '0;
            flash_on_q <= 1'b0;
            light_q    <= '0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            first_q    <= first_d;
            sync1_q    <= sensor;
            sync2_q    <= sync1_q;
            demand_q   <= demand_d;
            elapsed_q  <= elapsed_d;
            flash_on_q <= flash_on_d;
            light_q    <= light_d;
        end
    end

    assign light        = light_q;
    assign active_phase = active_q;
    assign demand       = demand_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

    localparam int NP   = 3;
    localparam int HZ   = 10;
    localparam int GMIN = 5;
    localparam int GMAX = 30;
    localparam int YT   = 3;
    localparam int ART  = 1;

    logic            clk    = 1'b0;
    logic            reset  = 1'b0;
    logic            enable = 1'b1;
    logic [NP-1:0]   sensor = '0;
    logic [2*NP-1:0] light;
    logic [2:0]      active_phase;
    logic [NP-1:0]   demand;

    int checks = 0;
    int errors = 0;

    traffic_phase_ctrl #(
        .N_PHASES (NP),
        .CLK_HZ   (HZ)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sensor       (sensor),
        .light        (light),
        .active_phase (active_phase),
        .demand       (demand)
    );

    always #5 clk = ~clk;

    // Model: mode plus cycles spent in it; timings are seconds * HZ cycles.
    typedef enum int {M_ALLRED, M_GREEN, M_YELLOW, M_FLASH} mmode_t;

    mmode_t          m_mode  = M_ALLRED;
    mmode_t          m_next  = M_ALLRED;
    int              m_cyc   = 0;
    int              m_act   = 0;
    int              m_nact  = 0;
    bit              m_first = 1'b1;
    bit              m_go    = 1'b0;
    bit [NP-1:0]     m_dem   = '0;
    bit [NP-1:0]     m_nd    = '0;
    bit [NP-1:0]     m_oth   = '0;
    bit [NP-1:0]     m_s1    = '0;
    bit [NP-1:0]     m_s2    = '0;
    logic [2*NP-1:0] exp_light = '0;

    function automatic int pick(input int a, input bit [NP-1:0] d);
        for (int k = 1; k <= NP; k++) begin
            if (d[(a + k) % NP]) return (a + k) % NP;
        end
        return (a + 1) % NP;
    endfunction

    function automatic logic [2*NP-1:0] light_of(input mmode_t md, input int a, input int c);
        logic [2*NP-1:0] l;
        l = '0;
        for (int p = 0; p < NP; p++) begin
            if (md == M_GREEN && p == a)  l[2*p +: 2] = 2'b01;
            if (md == M_YELLOW && p == a) l[2*p +: 2] = 2'b10;
            if (md == M_FLASH)            l[2*p +: 2] = (((c / HZ) % 2) == 0) ? 2'b10 : 2'b11;
        end
        return l;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_mode = M_ALLRED; m_cyc = 0; m_act = 0; m_first = 1'b1;
                m_dem = '0; m_s1 = '0; m_s2 = '0; exp_light = '0;
            end else begin
                exp_light = light_of(m_mode, m_act, m_cyc);
                m_next = m_mode; m_nact = m_act; m_go = 1'b0;
                m_oth = m_dem; m_oth[m_act] = 1'b0;
                case (m_mode)
                    M_ALLRED: if (m_cyc >= ART*HZ - 1) begin
                        if (!enable) m_next = M_FLASH;
                        else begin
                            m_next = M_GREEN; m_go = 1'b1;
                            m_nact = m_first ? 0 : pick(m_act, m_dem);
                        end
                    end
                    M_GREEN: if (!enable || (m_cyc >= GMIN*HZ - 1 && m_oth != 0 &&
                                             (!m_s2[m_act] || m_cyc >= GMAX*HZ - 1)))
                        m_next = M_YELLOW;
                    M_YELLOW: if (m_cyc >= YT*HZ - 1) m_next = M_ALLRED;
                    M_FLASH:  if (enable) m_next = M_ALLRED;
                    default:  m_next = M_ALLRED;
                endcase
                for (int p = 0; p < NP; p++) begin
                    m_nd[p] = m_dem[p] | (m_s2[p] && !(m_mode == M_GREEN && p == m_act));
                    if (m_go && p == m_nact) m_nd[p] = 1'b0;
                end
                m_dem = m_nd;
                m_s2  = m_s1;
                m_s1  = sensor;
                m_cyc = (m_next != m_mode) ? 0 : m_cyc + 1;
                if (m_go) m_first = 1'b0;
                m_mode = m_next;
                m_act  = m_nact;
            end
        end
    end

    initial begin
        int nonred;
        forever begin
            @(negedge clk);
            checks++;
            if (light !== exp_light) begin
                errors++;
                $display("FAIL model_light t=%0t got %b expected %b", $time, light, exp_light);
            end
            checks++;
            if (active_phase !== 3'(m_act)) begin
                errors++;
                $display("FAIL model_active t=%0t got %0d expected %0d", $time, active_phase, m_act);
            end
            checks++;
            if (demand !== m_dem) begin
                errors++;
                $display("FAIL model_demand t=%0t got %b expected %b", $time, demand, m_dem);
            end
            nonred = 0;
            for (int p = 0; p < NP; p++) if (light[2*p +: 2] != 2'b00) nonred++;
            checks++;
            if (nonred > 1 && light !== 6'b101010 && light !== 6'b111111) begin
                errors++;
                $display("FAIL safety t=%0t light %b has %0d non-red phases", $time, light, nonred);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic wait_light(input string name, input logic [2*NP-1:0] want, input int budget);
        int n;
        n = 0;
        while (light !== want && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (light !== want) begin
            errors++;
            $display("FAIL %s timeout got %b expected %b", name, light, want);
        end
    endtask

    initial begin
        int run;
        step(3);
        check_val("rst_light", 32'(light), 32'h0);
        check_val("rst_active", 32'(active_phase), 32'h0);
        check_val("rst_demand", 32'(demand), 32'h0);
        reset = 1'b1;

        step(5);
        check_val("allred_hold", 32'(light), 32'h0);
        step(6);
        check_val("p0_first_green", 32'(light), 32'b000001);
        check_val("p0_active", 32'(active_phase), 32'h0);
        step(100);
        check_val("p0_rest", 32'(light), 32'b000001);

        sensor[2] = 1'b1;
        step(1);
        sensor[2] = 1'b0;
        step(19);
        check_val("gap_yellow", 32'(light), 32'b000010);
        check_val("gap_demand2", 32'(demand), 32'b100);
        step(20);
        check_val("gap_allred", 32'(light), 32'h0);
        step(10);
        check_val("p2_green", 32'(light), 32'b010000);
        check_val("p2_active", 32'(active_phase), 32'd2);
        check_val("p2_demand_clr", 32'(demand), 32'h0);

        sensor[0] = 1'b1;
        wait_light("p0_regreen", 6'b000001, 100);
        sensor[1] = 1'b1;
        run = 1;
        for (int i = 0; i < 400; i++) begin
            step(1);
            sensor[1] = 1'b0;
            if (light !== 6'b000001) break;
            run++;
        end
        check_val("maxgreen_len", 32'(run), 32'd300);
        check_val("maxgreen_yellow", 32'(light), 32'b000010);
        sensor[0] = 1'b0;
        step(200);

        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(11);
        check_val("rr_start", 32'(light), 32'b000001);
        sensor = 3'b110;
        step(1);
        sensor = 3'b000;
        wait_light("rr_first_p1", 6'b000100, 200);
        check_val("rr_active1", 32'(active_phase), 32'd1);
        wait_light("rr_then_p2", 6'b010000, 300);
        check_val("rr_active2", 32'(active_phase), 32'd2);

        step(5);
        enable = 1'b0;
        step(45);
        check_val("flash_yellow", 32'(light), 32'b101010);
        step(10);
        check_val("flash_off", 32'(light), 32'b111111);
        step(10);
        check_val("flash_yellow2", 32'(light), 32'b101010);
        step(5);
        enable = 1'b1;
        step(5);
        check_val("unflash_allred", 32'(light), 32'h0);
        step(10);
        check_val("unflash_green", 32'(light), 32'b000001);
        check_val("unflash_active", 32'(active_phase), 32'd0);

        sensor[1] = 1'b1;
        step(1);
        sensor[1] = 1'b0;
        step(54);
        check_val("pre_rst_yellow", 32'(light), 32'b000010);
        check_val("pre_rst_demand", 32'(demand), 32'b010);
        reset = 1'b0;
        #1;
        check_val("async_rst_light", 32'(light), 32'h0);
        check_val("async_rst_demand", 32'(demand), 32'h0);
        check_val("async_rst_active", 32'(active_phase), 32'h0);
        step(2);
        reset = 1'b1;
        step(11);
        check_val("restart_p0", 32'(light), 32'b000001);
        step(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
